// File: rtl/lsu_axi_master_pkg.sv
// Shared encodings for the LSU bus front-end: access sizes, AXI response codes, FSM states.
package lsu_axi_master_pkg;

  localparam logic [1:0] SIZE_B    = 2'b00;
  localparam logic [1:0] SIZE_H    = 2'b01;
  localparam logic [1:0] SIZE_W    = 2'b10;
  localparam logic [1:0] SIZE_RSV  = 2'b11;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    IDLE,
    RADDR,
    RDATA,
    WRITE,
    WRESP,
    RESP
  } state_e;

  typedef struct packed {
    logic        wen;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] wdata;
  } req_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    return (size == SIZE_RSV) || ((size == SIZE_H) && off[0]) || ((size == SIZE_W) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store data/strobe placement and load extraction with sign/zero extension.
// Purely combinational; no handshake.
module lsu_lane_align
  import lsu_axi_master_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        sgn,
  input  logic [31:0] st_data,
  output logic [31:0] st_lanes,
  output logic [3:0]  st_strb,
  input  logic [31:0] ld_data,
  output logic [31:0] ld_ext
);

  logic [3:0]  strb_base;
  logic [15:0] ld_low;

  always_comb begin
    st_lanes = st_data << {offset, 3'b000};
    case (size)
      SIZE_B:  strb_base = 4'b0001;
      SIZE_H:  strb_base = 4'b0011;
      default: strb_base = 4'b1111;
    endcase
    // Half at offset 3 (only reachable with misalign checking off) loses its upper lane.
    st_strb = strb_base << offset;
  end

  always_comb begin
    ld_low = 16'(ld_data >> {offset, 3'b000});
    case (size)
      SIZE_B:  ld_ext = {{24{sgn & ld_low[7]}}, ld_low[7:0]};
      SIZE_H:  ld_ext = {{16{sgn & ld_low[15]}}, ld_low};
      default: ld_ext = ld_data;
    endcase
  end

endmodule

// File: rtl/lsu_axi_master.sv
// LSU data-side AXI-lite master: one request at a time, zero-wait load latency accept->resp_valid = 3 cycles.
// req_ready only in IDLE; AXI valids held until handshake; response held until resp_ready.
module lsu_axi_master
  import lsu_axi_master_pkg::*;
#(
  parameter int CHECK_MISALIGN = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  output logic        bready,
  input  logic [1:0]  bresp,
  input  logic        bvalid
);

  state_e      state, state_next;
  req_t        req_q;
  logic        aw_done, w_done;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        accept, misaligned, aw_hs, w_hs, write_done;
  logic [31:0] st_lanes, ld_ext;
  logic [3:0]  st_strb;

  assign accept     = req_valid && req_ready;
  assign misaligned = (CHECK_MISALIGN != 0) && is_misaligned(req_size, req_addr[1:0]);
  assign aw_hs      = awvalid && awready;
  assign w_hs       = wvalid && wready;
  assign write_done = (aw_done || aw_hs) && (w_done || w_hs);

  lsu_lane_align u_align (
    .size     (req_q.size),
    .offset   (req_q.addr[1:0]),
    .sgn      (req_q.sgn),
    .st_data  (req_q.wdata),
    .st_lanes (st_lanes),
    .st_strb  (st_strb),
    .ld_data  (rdata),
    .ld_ext   (ld_ext)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = misaligned ? RESP : (req_wen ? WRITE : RADDR);
      RADDR:   if (arready) state_next = RDATA;
      RDATA:   if (rvalid) state_next = RESP;
      WRITE:   if (write_done) state_next = WRESP;
      WRESP:   if (bvalid) state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      req_q   <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        req_q   <= '{wen: req_wen, addr: req_addr, size: req_size, sgn: req_signed, wdata: req_wdata};
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        rdata_q <= '0;
        err_q   <= misaligned;
      end
      if (state == WRITE) begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
      if ((state == RDATA) && rvalid) begin
        err_q   <= (rresp != RESP_OKAY);
        rdata_q <= (rresp != RESP_OKAY) ? '0 : ld_ext;
      end
      if ((state == WRESP) && bvalid) begin
        err_q   <= (bresp != RESP_OKAY);
        rdata_q <= '0;
      end
    end
  end

  always_comb begin
    req_ready  = (state == IDLE) && !reset;
    arvalid    = (state == RADDR);
    araddr     = (state == RADDR) ? req_q.addr : '0;
    rready     = (state == RDATA);
    awvalid    = (state == WRITE) && !aw_done;
    wvalid     = (state == WRITE) && !w_done;
    awaddr     = (state == WRITE) ? req_q.addr : '0;
    wdata      = (state == WRITE) ? st_lanes : '0;
    wstrb      = (state == WRITE) ? st_strb : '0;
    bready     = (state == WRESP);
    resp_valid = (state == RESP);
    resp_rdata = ((state == RESP) && !req_q.wen) ? rdata_q : '0;
    resp_err   = (state == RESP) && err_q;
  end

endmodule
